// File: rtl/sound_pkg.sv
// Shared sample types and constants for the audio filter scheduling path.
package sound_pkg;
   localparam int SAMPLE_W     = 24;
   localparam int WARM_DEFAULT = 6;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Minimum width of 1 keeps single-entry selects legal.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping; purely combinational.
module rr_arbiter import sound_pkg::*; #(
   parameter int N_CH = 4,
   parameter int CW   = clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CW-1:0]   ptr,
   output logic [N_CH-1:0] gnt,
   output logic [CW-1:0]   idx,
   output logic            any
);
   logic [CW:0]   s;
   logic [CW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      s   = '0;
      j   = '0;
      for (int k = 0; k < N_CH; k++) begin
         s = {1'b0, ptr} + (CW+1)'(k);
         if (s >= (CW+1)'(N_CH)) s = s - (CW+1)'(N_CH);
         j = s[CW-1:0];
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
endmodule

// File: rtl/filter_sched.sv
// Round-robin scheduler sharing one filter datapath across N_CH channels; one sample in flight per channel.
// Issue is registered (one cycle to dp_*); results return LAT cycles after accept; stalls on dp_ready or a full output slot.
module filter_sched import sound_pkg::*; #(
   parameter int  N_CH = 4,
   parameter int  LAT  = 1,
   parameter int  WARM = WARM_DEFAULT,
   localparam int CW   = clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH*SAMPLE_W-1:0] in_data,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   input  logic [N_CH-1:0]          filter_en,
   output logic [SAMPLE_W-1:0]      dp_data,
   output logic [CW-1:0]            dp_ch,
   output logic                     dp_filter_on,
   output logic                     dp_valid,
   input  logic                     dp_ready,
   input  logic [SAMPLE_W-1:0]      res_data,
   input  logic                     res_valid,
   output logic [N_CH*SAMPLE_W-1:0] out_data,
   output logic [N_CH-1:0]          out_valid,
   input  logic [N_CH-1:0]          out_ready,
   output logic                     err
);
   localparam int WW = clog2(WARM + 1);

   typedef struct packed {
      logic          vld;
      logic [CW-1:0] ch;
   } tag_t;

   logic [N_CH-1:0] inflight, en_q, eligible, req, gnt;
   logic [CW-1:0]   rr, gidx;
   logic            grant_any, dp_accept, take_on;
   logic [WW-1:0]   warm [N_CH];
   sample_t         in_arr [N_CH];
   sample_t         out_slot [N_CH];
   tag_t            tag [LAT];
   tag_t            fin;

   for (genvar i = 0; i < N_CH; i++) begin : g_lanes
      assign in_arr[i]                          = in_data[i*SAMPLE_W +: SAMPLE_W];
      assign out_data[i*SAMPLE_W +: SAMPLE_W]   = out_slot[i];
   end

   // A channel may have only one sample anywhere between issue and its output slot.
   assign eligible  = in_valid & ~out_valid & ~inflight;
   assign req       = (!reset && (!dp_valid || dp_ready)) ? eligible : '0;
   assign in_ready  = gnt;
   assign dp_accept = dp_valid && dp_ready;
   assign fin       = tag[LAT-1];

   rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_arb (
      .req (req),
      .ptr (rr),
      .gnt (gnt),
      .idx (gidx),
      .any (grant_any)
   );

   // An enable edge always bypasses; the filter engages only once the history is fully refilled.
   always_comb begin
      take_on = 1'b0;
      if (filter_en[gidx] == en_q[gidx])
         take_on = en_q[gidx] && (warm[gidx] == WW'(WARM));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_valid     <= 1'b0;
         dp_data      <= '0;
         dp_ch        <= '0;
         dp_filter_on <= 1'b0;
         rr           <= '0;
         inflight     <= '0;
         en_q         <= '0;
         out_valid    <= '0;
         err          <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            warm[i]     <= '0;
            out_slot[i] <= '0;
         end
         for (int s = 0; s < LAT; s++) tag[s] <= '0;
      end else begin
         if (grant_any) begin
            dp_data      <= in_arr[gidx];
            dp_ch        <= gidx;
            dp_filter_on <= take_on;
            dp_valid     <= 1'b1;
            rr           <= (int'(gidx) == N_CH - 1) ? '0 : gidx + CW'(1);
            if (filter_en[gidx] != en_q[gidx]) begin
               en_q[gidx] <= filter_en[gidx];
               warm[gidx] <= '0;
            end else if (en_q[gidx] && warm[gidx] < WW'(WARM)) begin
               warm[gidx] <= warm[gidx] + WW'(1);
            end
         end else if (dp_accept) begin
            dp_valid <= 1'b0;
         end

         tag[0] <= '{vld: dp_accept, ch: dp_ch};
         for (int s = 1; s < LAT; s++) tag[s] <= tag[s-1];

         out_valid <= out_valid & ~out_ready;
         if (res_valid && fin.vld) begin
            out_slot[fin.ch]  <= res_data;
            out_valid[fin.ch] <= 1'b1;
            inflight[fin.ch]  <= 1'b0;
         end else if (res_valid) begin
            err <= 1'b1;
         end else if (fin.vld) begin
            // Missing result: flag it but free the channel so it cannot wedge.
            err              <= 1'b1;
            inflight[fin.ch] <= 1'b0;
         end
         if (grant_any) inflight[gidx] <= 1'b1;
      end
   end
endmodule

// File: doc/filter_sched.md
Name: filter_sched

Overview:
- Round-robin scheduler that time-multiplexes one shared 24-bit sample-filter datapath (moving-average core with per-channel history banks indexed by dp_ch) between N_CH audio source channels.
- Tags each issued sample with its channel, routes each result back to a per-channel output holding slot, and sequences the filter enable per channel.
- Handles the filter enable with a warm-up bypass, so stale delay-line history is never heard.
- Sits between the per-channel input streams and the mixer summing stage.

Parameters:
- N_CH, 4, number of source channels (2..8).
- LAT, 1, fixed datapath latency in cycles from dp accept to res_valid (1..4).
- WARM, 6, accepted samples a channel stays in bypass after its filter enable rises.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  N_CH*24  packed channel samples; channel i occupies bits [24i+23:24i]; signed.
- in_valid  in  N_CH  per-channel sample valid.
- in_ready  out  N_CH  per-channel accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
- filter_en  in  N_CH  per-channel filter request, level.
- dp_data  out  24  sample to datapath.
- dp_ch  out  clog2(N_CH)  channel tag / history bank select.
- dp_filter_on  out  1  filter enable for this sample.
- dp_valid  out  1  datapath request valid.
- dp_ready  in  1  datapath accept.
- res_data  in  24  datapath result.
- res_valid  in  1  result strobe, exactly LAT cycles after a dp accept.
- out_data  out  N_CH*24  packed per-channel results.
- out_valid  out  N_CH  per-channel result valid.
- out_ready  in  N_CH  per-channel consumer ready.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async): all of the following are cleared.
  - Outputs: dp_valid, out_valid, in_ready, err = 0; dp_data, dp_ch, out_data = 0.
  - State: rr pointer = 0, inflight = 0, tag pipe empty, en_q = 0, warm counters = 0.
- Eligibility:
  - Channel i is eligible when in_valid[i], out_valid[i]=0 and inflight[i]=0.
  - This enforces at most one outstanding sample per channel, so a result never collides with an occupied slot.
- Issue stage:
  - dp register is loadable when dp_valid=0 or (dp_valid and dp_ready).
  - When loadable and some channel is eligible, the arbiter grants g, the first eligible index at or after rr (wrapping).
  - in_ready is combinational and one-hot: in_ready[g]=1 that cycle, all others 0. No grant means in_ready=0.
  - On transfer, the next edge sets: dp_data<=sample g, dp_ch<=g, dp_filter_on per the warm-up rule, dp_valid<=1, inflight[g]<=1, rr<=(g+1) mod N_CH.
  - dp outputs hold stable while dp_valid=1 and dp_ready=0.
  - dp_valid drops when an accept occurs with nothing new granted.
  - Back-to-back issue at one sample per cycle is allowed.
- Tag pipe:
  - LAT-stage shift register of {valid, ch}, loaded on dp accept.
  - When res_valid=1 and the final stage is valid: out_data[ch]<=res_data, out_valid[ch]<=1, inflight[ch]<=0.
  - res_valid=1 with the final stage empty sets err and discards the result.
  - A valid final stage with res_valid=0 sets err and clears inflight[ch], so the channel cannot lock up.
- Output:
  - out_valid[i] clears on out_valid[i] and out_ready[i].
  - A clear on one channel and a fill on another in the same cycle are both applied.
- Warm-up sequencing, evaluated at the grant of channel g:
  - If filter_en[g] differs from en_q[g]: en_q[g]<=filter_en[g] and warm[g]<=0. The sample is issued with dp_filter_on=0.
  - Otherwise dp_filter_on = en_q[g] and (warm[g]==WARM).
  - If en_q[g]=1 and warm[g]<WARM, warm[g] increments (saturating at WARM).
  - Result: a channel whose filter enable rises passes exactly WARM+1 bypass samples before filtered output starts.
  - Falling filter_en takes effect on the next granted sample.
  - filter_en changes on non-granted channels are ignored until that channel is granted.
- Arithmetic: the block performs no arithmetic on samples; widths pass through unmodified.
- Reset mid-operation: all in-flight samples are dropped. The datapath shares reset, so no stale res_valid follows.

Decomposition:
- Shared package sound_pkg: SAMPLE_W=24, sample_t (signed 24-bit), default WARM=6, clog2 helper.
- One sub-module, rr_arbiter: N_CH requests plus rr pointer in, one-hot grant and index out, purely combinational.
- Tag pipe and warm-up counters stay in the top.

Test Plan:
- All 4 channels valid continuously, dp_ready=1, out_ready=1, LAT=1.
  -> Grants cycle 0,1,2,3,0…; out_valid pulses in the same order; each out_data equals the res_data echoed by the model.
- Channel 2 out_ready=0, others streaming.
  -> Channel 2 gets exactly one sample, then is skipped; the other channels continue round-robin; no err.
- dp_ready held low 3 cycles with dp_valid=1.
  -> dp_data and dp_ch stable for all 3 cycles; in_ready all 0; issue resumes when dp_ready rises.
- filter_en[1] rises, channel 1 streaming 10 samples.
  -> dp_filter_on=0 for the first 7 channel-1 issues and 1 from the 8th; filter_en[1] falls -> next issue has 0.
- Model injects res_valid with the tag pipe empty.
  -> err=1 and remains 1; no out_valid change; only reset clears err.
- Assert reset mid-burst with inflight on 3 channels.
  -> All outputs 0 immediately (async); after release the first grant is channel 0.
